pcm_stereo_fifo: RTL and testbench
==================================

Name: pcm_stereo_fifo

Overview:
Stereo sample FIFO that sits directly downstream of the I2S-to-PCM deserializer. It captures each completed left/right PCM word pair on a one-cycle valid strobe and buffers it for a slower or bursty consumer, which drains it through a valid/ready handshake. Overflow is tracked with a sticky flag and a saturating drop counter, because the upstream I2S stream cannot be back-pressured.

Parameters:
NUMBER_OF_BITS, 8, width of each PCM channel word
DEPTH, 16, number of stereo entries; power of two, at least 2
ADDR_BITS, log2(DEPTH) (4 at default), pointer width; derived, not overridden

Ports:
clk  in  1  single system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  one-cycle strobe: in_left/in_right hold a new stereo pair
in_left  in  NUMBER_OF_BITS  left-channel PCM word
in_right  in  NUMBER_OF_BITS  right-channel PCM word
out_valid  out  1  FIFO non-empty; head entry is presented
out_ready  in  1  consumer accepts the head entry when out_valid is high
out_left  out  NUMBER_OF_BITS  head entry, left channel
out_right  out  NUMBER_OF_BITS  head entry, right channel
level  out  ADDR_BITS+1  number of stored entries, 0..DEPTH
flush  in  1  synchronous empty; does not clear overflow status
clear_ovf  in  1  clears overflow and drop_count
overflow  out  1  sticky: at least one pair was dropped
drop_count  out  8  dropped pairs, saturating at 255

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Storage: register array of DEPTH x (2*NUMBER_OF_BITS). Write and read pointers are ADDR_BITS wide and wrap modulo DEPTH. A separate count register holds 0..DEPTH.
- Reset:
  - Sets pointers, count, overflow and drop_count to 0.
  - Array contents are not reset.
  - Outputs after reset: out_valid=0, level=0, out_left=out_right=0, overflow=0, drop_count=0.
- pop = out_valid & out_ready. push = in_valid & (count<DEPTH | pop).
- Push: writes {in_left,in_right} at the write pointer, then increments the write pointer.
- Pop: increments the read pointer.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Latency: a pair pushed at edge k has out_valid=1 and data on out_left/out_right from cycle k+1 onward. There is no fall-through in the same cycle.
- out_valid = (count != 0). out_left/out_right show mem[read pointer] while out_valid=1, and are forced to 0 when empty.
- Empty with in_valid & out_ready: no pop occurs; the push proceeds; level becomes 1.
- Full with in_valid & pop: both occur; level stays DEPTH; the new pair lands in the freed slot.
- Full with in_valid & no pop: the incoming pair is dropped and the stored data is unchanged. overflow is set to 1, and drop_count increments unless already 255.
- Output stability: while out_valid=1 and out_ready=0, out_left/out_right are held stable.
- flush:
  - Zeroes both pointers and count at the next edge, taking priority over push and pop in the same cycle; the in_valid pair that cycle is discarded and is not counted as dropped.
  - overflow and drop_count are kept.
- clear_ovf zeroes overflow and drop_count. If a drop occurs in the same cycle, the set wins: overflow=1, drop_count=1.
- Precedence: reset > flush > push/pop.
- Reset asserted mid-burst takes effect at the next edge regardless of the handshake state.

Test Plan:
- Reset, then push 3 pairs (L/R = 0x11/0x81, 0x22/0x82, 0x33/0x83) with out_ready=0 -> level=3, out_valid=1, out_left=0x11, out_right=0x81 held stable.
- Set out_ready=1 for 3 cycles -> pairs 0x11/0x81, 0x22/0x82, 0x33/0x83 are read in order, then out_valid=0, level=0, outputs=0x00.
- Push 20 pairs (L=i, R=0xFF-i for i=0..19) with no pops -> level=16, overflow=1, drop_count=4; draining yields i=0..15 only.
- At full, drive in_valid and out_ready in the same cycle with pair 0xAA/0x55 -> level stays 16, head advances, and 0xAA/0x55 emerges as the 16th read.
- Push 5 pairs, then assert flush together with in_valid -> level=0, out_valid=0, drop_count unchanged; assert clear_ovf -> overflow=0, drop_count=0.
- Empty FIFO with in_valid=1, out_ready=1 -> no pop, level=1 after the edge. Then assert reset with 1 entry held -> level=0, out_valid=0, out_left=0 on the next cycle.

Source files
------------

// File: rtl/pcm_stereo_fifo_if.sv
// pcm_stereo_fifo_if: stereo pcm capture, drain handshake and overflow status bundle
interface pcm_stereo_fifo_if #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int DEPTH = 16
);
  localparam int ADDR_BITS = $clog2(DEPTH);
  logic in_valid;
  logic [NUMBER_OF_BITS-1:0] in_left;
  logic [NUMBER_OF_BITS-1:0] in_right;
  logic out_valid;
  logic out_ready;
  logic [NUMBER_OF_BITS-1:0] out_left;
  logic [NUMBER_OF_BITS-1:0] out_right;
  logic [ADDR_BITS:0] level;
  logic flush;
  logic clear_ovf;
  logic overflow;
  logic [7:0] drop_count;
  modport master (
    output in_valid, in_left, in_right, out_ready, flush, clear_ovf,
    input out_valid, out_left, out_right, level, overflow, drop_count
  );
  modport slave (
    input in_valid, in_left, in_right, out_ready, flush, clear_ovf,
    output out_valid, out_left, out_right, level, overflow, drop_count
  );
endinterface

// File: rtl/pcm_stereo_fifo.sv
// pcm_stereo_fifo: stereo pcm sample fifo with sticky overflow and saturating drop counter
module pcm_stereo_fifo #(
  parameter int NUMBER_OF_BITS = 8,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic reset,
  pcm_stereo_fifo_if.slave bus
);
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int W = 2 * NUMBER_OF_BITS;
  logic [W-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0] count;
  logic [W-1:0] head;
  logic out_valid;
  logic push;
  logic pop;
  logic drop;
  logic overflow;
  logic [7:0] drop_count;
  always_comb begin
    out_valid = count != '0;
    pop = out_valid & bus.out_ready;
    push = bus.in_valid & ((count < (ADDR_BITS+1)'(DEPTH)) | pop);
    drop = bus.in_valid & ~push & ~bus.flush;
    head = out_valid ? mem[rd_ptr] : '0;
  end
  assign bus.out_valid = out_valid;
  assign bus.out_left = head[W-1:NUMBER_OF_BITS];
  assign bus.out_right = head[NUMBER_OF_BITS-1:0];
  assign bus.level = count;
  assign bus.overflow = overflow;
  assign bus.drop_count = drop_count;
  always_ff @(posedge clk)
    if (push & ~bus.flush & ~reset) mem[wr_ptr] <= {bus.in_left, bus.in_right};
  always_ff @(posedge clk) begin
    if (reset | bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + ADDR_BITS'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + ADDR_BITS'(1) : rd_ptr;
      count <= count + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_count <= bus.clear_ovf ? 8'd1 : drop_count + {7'd0, drop_count != 8'hFF};
    end else if (bus.clear_ovf) begin
      overflow <= 1'b0;
      drop_count <= '0;
    end
  end
endmodule

// File: tb/tb_pcm_stereo_fifo.sv
// tb_pcm_stereo_fifo: scoreboard bench for pcm_stereo_fifo with directed vectors
module tb_pcm_stereo_fifo;
  typedef struct {
    string name;
    int lvl;
    bit vld;
    bit ovf;
    int drops;
    bit has_head;
    logic [7:0] hl;
    logic [7:0] hr;
  } status_t;
  logic clk = 0;
  logic reset = 1;
  logic done = 0;
  int checks = 0;
  int errors = 0;
  logic [15:0] sb [$];
  status_t st [$];
  pcm_stereo_fifo_if #(.NUMBER_OF_BITS(8), .DEPTH(16)) bus ();
  pcm_stereo_fifo #(.NUMBER_OF_BITS(8), .DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) chk("unexpected_pop", 1, 0);
      else begin
        chk("pop_left", int'(bus.out_left), int'(sb[0][15:8]));
        chk("pop_right", int'(bus.out_right), int'(sb[0][7:0]));
        void'(sb.pop_front());
      end
    end
    while (st.size() > 0) begin
      status_t s;
      s = st.pop_front();
      chk({s.name, "_level"}, int'(bus.level), s.lvl);
      chk({s.name, "_valid"}, int'(bus.out_valid), int'(s.vld));
      chk({s.name, "_overflow"}, int'(bus.overflow), int'(s.ovf));
      chk({s.name, "_drops"}, int'(bus.drop_count), s.drops);
      if (s.has_head) begin
        chk({s.name, "_head_l"}, int'(bus.out_left), int'(s.hl));
        chk({s.name, "_head_r"}, int'(bus.out_right), int'(s.hr));
      end
      if (s.lvl == 0) begin
        chk({s.name, "_zero_l"}, int'(bus.out_left), 0);
        chk({s.name, "_zero_r"}, int'(bus.out_right), 0);
      end
    end
    if (done) begin
      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_st(input string n, input int l, input bit v, input bit o, input int d,
                           input bit h, input logic [7:0] hl, input logic [7:0] hr);
    status_t s;
    s.name = n; s.lvl = l; s.vld = v; s.ovf = o; s.drops = d; s.has_head = h; s.hl = hl; s.hr = hr;
    st.push_back(s);
  endtask
  task automatic put(input logic [7:0] l, input logic [7:0] r, input bit accepted);
    bus.in_valid = 1;
    bus.in_left = l;
    bus.in_right = r;
    if (accepted) sb.push_back({l, r});
    step();
    bus.in_valid = 0;
  endtask
  initial begin
    bus.in_valid = 0; bus.in_left = 0; bus.in_right = 0;
    bus.out_ready = 0; bus.flush = 0; bus.clear_ovf = 0;
    step(); step();
    reset = 0;
    expect_st("reset", 0, 0, 0, 0, 0, 0, 0);
    step();
    put(8'h11, 8'h81, 1); put(8'h22, 8'h82, 1); put(8'h33, 8'h83, 1);
    expect_st("hold3", 3, 1, 0, 0, 1, 8'h11, 8'h81);
    step();
    expect_st("hold3_stable", 3, 1, 0, 0, 1, 8'h11, 8'h81);
    bus.out_ready = 1;
    step(); step(); step();
    bus.out_ready = 0;
    expect_st("drained", 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 20; i++) put(8'(i), 8'(8'hFF - i), i < 16);
    expect_st("full", 16, 1, 1, 4, 1, 8'h00, 8'hFF);
    step();
    bus.out_ready = 1;
    put(8'hAA, 8'h55, 1);
    bus.out_ready = 0;
    expect_st("full_pushpop", 16, 1, 1, 4, 1, 8'h01, 8'hFE);
    step();
    bus.out_ready = 1;
    for (int i = 0; i < 16; i++) step();
    bus.out_ready = 0;
    expect_st("drain16", 0, 0, 1, 4, 0, 0, 0);
    step();
    for (int i = 0; i < 5; i++) put(8'(8'h40 + i), 8'(8'hC0 + i), 1);
    expect_st("five", 5, 1, 1, 4, 1, 8'h40, 8'hC0);
    bus.flush = 1;
    put(8'h99, 8'h66, 0);
    bus.flush = 0;
    sb.delete();
    expect_st("flush", 0, 0, 1, 4, 0, 0, 0);
    bus.clear_ovf = 1;
    step();
    bus.clear_ovf = 0;
    expect_st("clear_ovf", 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 16; i++) put(8'(8'h60 + i), 8'(8'hE0 + i), 1);
    bus.clear_ovf = 1;
    put(8'hDE, 8'hAD, 0);
    bus.clear_ovf = 0;
    expect_st("clear_vs_drop", 16, 1, 1, 1, 1, 8'h60, 8'hE0);
    step();
    for (int i = 0; i < 260; i++) put(8'hBB, 8'hCC, 0);
    expect_st("saturate", 16, 1, 1, 255, 1, 8'h60, 8'hE0);
    bus.flush = 1;
    step();
    bus.flush = 0;
    sb.delete();
    bus.clear_ovf = 1;
    step();
    bus.clear_ovf = 0;
    expect_st("cleared2", 0, 0, 0, 0, 0, 0, 0);
    step();
    bus.out_ready = 1;
    put(8'h77, 8'hE7, 1);
    bus.out_ready = 0;
    expect_st("empty_rdy_push", 1, 1, 0, 0, 1, 8'h77, 8'hE7);
    step();
    reset = 1;
    step();
    reset = 0;
    sb.delete();
    expect_st("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    step();
    done = 1;
  end
endmodule
